// File: rtl/mult_control.sv
// Sequencing controller for the shift-add multiplier: drives load, add-select
// and add+shift enables of the product register and reports completion.
module mult_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             product_lsb,
    input  logic             ALU_carry,
    output logic             W_ctrl,
    output logic             ADD_ctrl,
    output logic             SRL_ctrl,
    output logic             Ready,
    output logic             busy,
    output logic             overflow,
    output logic [CNT_W-1:0] iter_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic             overflow_n;
    logic [CNT_W-1:0] count_n;
    logic             add_n;

    always_comb begin
        state_n    = state;
        overflow_n = overflow;
        count_n    = iter_count;
        add_n      = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n    = S_LOAD;
                    overflow_n = 1'b0;
                    count_n    = '0;
                end
            end
            S_LOAD: begin
                state_n = S_ITER;
                add_n   = product_lsb;
            end
            S_ITER: begin
                // A carry aborts the iteration without counting it.
                if (ALU_carry) begin
                    overflow_n = 1'b1;
                    state_n    = S_DONE;
                end else begin
                    count_n = iter_count + CNT_W'(1);
                    if (iter_count == LAST_ITER) begin
                        state_n = S_DONE;
                    end else begin
                        add_n = product_lsb;
                    end
                end
            end
            default: begin
                state_n    = S_IDLE;
                overflow_n = 1'b0;
                count_n    = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every control is a flop.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            W_ctrl     <= 1'b1;
            ADD_ctrl   <= 1'b0;
            SRL_ctrl   <= 1'b0;
            Ready      <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            iter_count <= '0;
        end else begin
            state      <= state_n;
            W_ctrl     <= (state_n == S_LOAD);
            ADD_ctrl   <= add_n;
            SRL_ctrl   <= (state_n == S_ITER);
            Ready      <= (state_n == S_DONE);
            busy       <= (state_n == S_LOAD) || (state_n == S_ITER);
            overflow   <= overflow_n;
            iter_count <= count_n;
        end
    end

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control: scoreboard of expected completion
// results plus per-scenario inline checks of the control sequence.
module tb_mult_control;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             Reset = 1'b0;
    logic             start = 1'b0;
    logic             product_lsb = 1'b0;
    logic             ALU_carry = 1'b0;
    logic             W_ctrl, ADD_ctrl, SRL_ctrl, Ready, busy, overflow;
    logic [CNT_W-1:0] iter_count;

    typedef struct {
        logic             ovf;
        logic [CNT_W-1:0] cnt;
        int               lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    localparam logic [11:0] RESET_VEC = 12'b1000_0000_0000;

    mult_control #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .Reset(Reset), .start(start), .product_lsb(product_lsb),
        .ALU_carry(ALU_carry), .W_ctrl(W_ctrl), .ADD_ctrl(ADD_ctrl),
        .SRL_ctrl(SRL_ctrl), .Ready(Ready), .busy(busy), .overflow(overflow),
        .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] obs_vec();
        return {W_ctrl, ADD_ctrl, SRL_ctrl, Ready, busy, overflow, iter_count};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b1;
        #1;
        n_cmp++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_poweron got=%b want=%b", obs_vec(), RESET_VEC);
        end
        tick(); tick();
        Reset = 1'b0;
        n_cmp++;
        if (W_ctrl !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_hold W_ctrl got=%b want=1", W_ctrl);
        end
        tick();
        n_cmp++;
        if (obs_vec() !== 12'd0) begin
            n_fail++; $display("FAIL reset_idle got=%b want=%b", obs_vec(), 12'd0);
        end
        // asynchronous assertion between edges
        #3 Reset = 1'b1;
        #1;
        n_cmp++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_async got=%b want=%b", obs_vec(), RESET_VEC);
        end
        tick();
        Reset = 1'b0;
        tick();
        n_cmp++;
        if (obs_vec() !== 12'd0) begin
            n_fail++; $display("FAIL reset_async_idle got=%b want=%b", obs_vec(), 12'd0);
        end
    endtask

    task automatic test_normal();
        int w_cyc, srl_cyc, rdy_edge;
        logic lsb;
        exp_t e;
        sb.push_back('{1'b0, CNT_W'(WIDTH), WIDTH + 1});
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({W_ctrl, busy, SRL_ctrl} !== 3'b110) begin
            n_fail++; $display("FAIL normal_load got W/busy/SRL=%b want=110", {W_ctrl, busy, SRL_ctrl});
        end
        w_cyc = 1; srl_cyc = 0; rdy_edge = -1;
        for (int c = 1; c <= 40 && rdy_edge < 0; c++) begin
            lsb = c[0];
            product_lsb = lsb;
            tick();
            if (W_ctrl) w_cyc++;
            if (SRL_ctrl) begin
                srl_cyc++;
                n_cmp++;
                if (ADD_ctrl !== lsb) begin
                    n_fail++; $display("FAIL normal_add c=%0d got=%b want=%b", c, ADD_ctrl, lsb);
                end
            end
            if (Ready) rdy_edge = c;
        end
        n_cmp++;
        if (w_cyc !== 1) begin
            n_fail++; $display("FAIL normal_w_cycles got=%0d want=1", w_cyc);
        end
        n_cmp++;
        if (srl_cyc !== WIDTH) begin
            n_fail++; $display("FAIL normal_srl_cycles got=%0d want=%0d", srl_cyc, WIDTH);
        end
        n_cmp++;
        if (rdy_edge !== WIDTH + 1) begin
            n_fail++; $display("FAIL normal_ready_edge got=%0d want=%0d", rdy_edge, WIDTH + 1);
        end
        n_cmp++;
        if (ADD_ctrl !== 1'b0 || SRL_ctrl !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL normal_done_ctrl got ADD/SRL/busy=%b want=000", {ADD_ctrl, SRL_ctrl, busy});
        end
        if (rdy_edge > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (overflow !== e.ovf || iter_count !== e.cnt || rdy_edge !== e.lat) begin
                n_fail++; $display("FAIL normal_sb got ovf=%b cnt=%0d lat=%0d want ovf=%b cnt=%0d lat=%0d",
                                   overflow, iter_count, rdy_edge, e.ovf, e.cnt, e.lat);
            end
        end
        sb.delete();
    endtask

    // Carry raised on the n-th ITER edge (edge n+1 after the start edge).
    task automatic test_carry(input int n);
        int rdy_edge;
        exp_t e;
        sb.push_back('{1'b1, CNT_W'(n - 1), n + 1});
        start = 1'b1;
        tick();
        start = 1'b0;
        rdy_edge = -1;
        for (int c = 1; c <= 40 && rdy_edge < 0; c++) begin
            ALU_carry = (c == n + 1);
            product_lsb = 1'($urandom);
            tick();
            if (Ready) rdy_edge = c;
        end
        ALU_carry = 1'b0;
        n_cmp++;
        if (rdy_edge !== n + 1) begin
            n_fail++; $display("FAIL carry%0d_ready_edge got=%0d want=%0d", n, rdy_edge, n + 1);
        end
        if (rdy_edge > 0 && sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (overflow !== e.ovf || iter_count !== e.cnt || rdy_edge !== e.lat) begin
                n_fail++; $display("FAIL carry%0d_sb got ovf=%b cnt=%0d lat=%0d want ovf=%b cnt=%0d lat=%0d",
                                   n, overflow, iter_count, rdy_edge, e.ovf, e.cnt, e.lat);
            end
        end
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({SRL_ctrl, Ready, overflow, iter_count} !== {3'b011, CNT_W'(n - 1)}) begin
                n_fail++; $display("FAIL carry%0d_hold got SRL/Ready/ovf/cnt=%b want=%b", n,
                                   {SRL_ctrl, Ready, overflow, iter_count}, {3'b011, CNT_W'(n - 1)});
            end
        end
    endtask

    task automatic test_back_to_back();
        int w_cnt, rise_cnt, op_start;
        logic prev_rdy;
        exp_t e;
        sb.push_back('{1'b0, CNT_W'(WIDTH), WIDTH + 1});
        sb.push_back('{1'b0, CNT_W'(WIDTH), WIDTH + 1});
        start = 1'b1;
        tick();
        n_cmp++;
        if ({W_ctrl, Ready, overflow, iter_count} !== {3'b100, CNT_W'(0)}) begin
            n_fail++; $display("FAIL b2b_first_load got W/Ready/ovf/cnt=%b want=%b",
                               {W_ctrl, Ready, overflow, iter_count}, {3'b100, CNT_W'(0)});
        end
        w_cnt = 1; rise_cnt = 0; op_start = 0; prev_rdy = 1'b0;
        for (int c = 1; c <= 75; c++) begin
            if (c == 2 * WIDTH + 3) start = 1'b0;
            tick();
            if (W_ctrl) begin
                w_cnt++;
                op_start = c;
                n_cmp++;
                if ({Ready, overflow, iter_count} !== {2'b00, CNT_W'(0)}) begin
                    n_fail++; $display("FAIL b2b_reload c=%0d got Ready/ovf/cnt=%b want=0", c,
                                       {Ready, overflow, iter_count});
                end
            end
            if (Ready && !prev_rdy) begin
                rise_cnt++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL b2b_sb_empty c=%0d got=extra_ready want=none", c);
                end else begin
                    e = sb.pop_front();
                    if (overflow !== e.ovf || iter_count !== e.cnt || c - op_start !== e.lat) begin
                        n_fail++; $display("FAIL b2b_sb got ovf=%b cnt=%0d lat=%0d want ovf=%b cnt=%0d lat=%0d",
                                           overflow, iter_count, c - op_start, e.ovf, e.cnt, e.lat);
                    end
                end
            end
            prev_rdy = Ready;
        end
        n_cmp++;
        if (w_cnt !== 2) begin
            n_fail++; $display("FAIL b2b_load_count got=%0d want=2", w_cnt);
        end
        n_cmp++;
        if (rise_cnt !== 2) begin
            n_fail++; $display("FAIL b2b_ready_count got=%0d want=2", rise_cnt);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        bit found;
        int rdy_edge;
        exp_t e;
        sb.push_back('{1'b0, CNT_W'(WIDTH), WIDTH + 1});
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 1; c <= 40 && !found; c++) begin
            tick();
            if (iter_count == CNT_W'(10)) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_fail++; $display("FAIL rstmid_reach10 got cnt=%0d want=10", iter_count);
        end
        #3 Reset = 1'b1;
        #1;
        sb.delete();
        n_cmp++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL rstmid_async got=%b want=%b", obs_vec(), RESET_VEC);
        end
        tick(); tick();
        n_cmp++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL rstmid_hold got=%b want=%b", obs_vec(), RESET_VEC);
        end
        Reset = 1'b0;
        tick();
        n_cmp++;
        if (obs_vec() !== 12'd0) begin
            n_fail++; $display("FAIL rstmid_idle got=%b want=%b", obs_vec(), 12'd0);
        end
        sb.push_back('{1'b0, CNT_W'(WIDTH), WIDTH + 1});
        start = 1'b1;
        tick();
        start = 1'b0;
        rdy_edge = -1;
        for (int c = 1; c <= 40 && rdy_edge < 0; c++) begin
            product_lsb = 1'($urandom);
            tick();
            if (Ready) rdy_edge = c;
        end
        n_cmp++;
        if (rdy_edge < 0 || sb.size() == 0) begin
            n_fail++; $display("FAIL rstmid_rerun got=no_ready want=ready");
        end else begin
            e = sb.pop_front();
            if (overflow !== e.ovf || iter_count !== e.cnt || rdy_edge !== e.lat) begin
                n_fail++; $display("FAIL rstmid_sb got ovf=%b cnt=%0d lat=%0d want ovf=%b cnt=%0d lat=%0d",
                                   overflow, iter_count, rdy_edge, e.ovf, e.cnt, e.lat);
            end
        end
        sb.delete();
    endtask

    task automatic test_invariants();
        for (int c = 0; c < 10000; c++) begin
            start = ($urandom_range(0, 7) == 0);
            ALU_carry = ($urandom_range(0, 63) == 0);
            product_lsb = 1'($urandom);
            tick();
            n_cmp++;
            if ((W_ctrl & SRL_ctrl) !== 1'b0) begin
                n_fail++; $display("FAIL inv_w_srl c=%0d got=%b want=0", c, W_ctrl & SRL_ctrl);
            end
            n_cmp++;
            if ((Ready & busy) !== 1'b0 || (Ready & SRL_ctrl) !== 1'b0) begin
                n_fail++; $display("FAIL inv_ready c=%0d got Ready/busy/SRL=%b want not both", c,
                                   {Ready, busy, SRL_ctrl});
            end
            n_cmp++;
            if (!(int'(iter_count) <= WIDTH)) begin
                n_fail++; $display("FAIL inv_count c=%0d got=%0d want<=%0d", c, iter_count, WIDTH);
            end
        end
        start = 1'b0;
        ALU_carry = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_carry(6);
        test_carry(WIDTH);
        test_back_to_back();
        test_reset_mid();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
